// File: rtl/pht_update_buffer_pkg.sv
// Shared gshare PHT sizing constants for the update path and the predictor.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pht_update_buffer_pkg;

  // PHT index width.
  localparam int GSH_PHT_ENT_SEL       = 10;
  // Width of a PHT 2-bit saturating counter.
  localparam int GSH_PHT_DATA_WIDTH    = 2;
  // Entries in the PHT update queue.
  localparam int GSH_PHT_UPD_BUF_DEPTH = 4;

endpackage

// File: rtl/pht_sat_cnt.sv
// Saturating up/down step of a PHT counter; shared with the speculative path.
// Latency: combinational.
// Backpressure: none.
module pht_sat_cnt #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_taken,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Step toward taken/not-taken, pinning at the extremes instead of wrapping.
  always_comb begin
    o_cnt = i_cnt;
    if (i_taken) begin
      if (i_cnt != CNT_MAX) o_cnt = i_cnt + CNT_ONE;
    end else begin
      if (i_cnt != '0) o_cnt = i_cnt - CNT_ONE;
    end
  end

endmodule

// File: rtl/pht_update_buffer.sv
// Queues up to two in-order PHT updates per cycle and drains one per cycle to the PHT write port.
// Latency: accepted at edge N, popped at edge N+1 at the earliest, o_wr_* valid the cycle after.
// Backpressure: o_upd_ready low once fewer than two free entries remain (registered count only).
module pht_update_buffer
  import pht_update_buffer_pkg::*;
#(
  parameter int DEPTH  = GSH_PHT_UPD_BUF_DEPTH,
  parameter int ADDR_W = GSH_PHT_ENT_SEL,
  parameter int CNT_W  = GSH_PHT_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_upd_valid_1,
  input  logic [ADDR_W-1:0] i_upd_addr_1,
  input  logic [CNT_W-1:0]  i_upd_cnt_1,
  input  logic              i_upd_taken_1,
  input  logic              i_upd_valid_2,
  input  logic [ADDR_W-1:0] i_upd_addr_2,
  input  logic [CNT_W-1:0]  i_upd_cnt_2,
  input  logic              i_upd_taken_2,
  output logic              o_upd_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [CNT_W-1:0]  o_wr_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cnt;
    logic              taken;
  } upd_t;

  upd_t              mem_q [DEPTH];
  upd_t              mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]  wr_data_q, wr_data_d;

  logic              push_1, push_2, pop;
  upd_t              head;
  logic [CNT_W-1:0]  base_cnt;
  logic [CNT_W-1:0]  next_cnt;

  assign o_upd_ready = (count_q <= READY_MAX);
  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;

  // Head entry and its base counter: build on the in-flight write when it hits the same index.
  always_comb begin
    head     = mem_q[rd_ptr_q];
    base_cnt = head.cnt;
    if (wr_en_q && (wr_addr_q == head.addr)) base_cnt = wr_data_q;
  end

  pht_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_sat_cnt (
    .i_cnt  (base_cnt),
    .i_taken(head.taken),
    .o_cnt  (next_cnt)
  );

  // Queue push/pop bookkeeping and next PHT write; slot 1 always lands ahead of slot 2.
  always_comb begin
    mem_d     = mem_q;
    push_1    = o_upd_ready & i_upd_valid_1;
    push_2    = o_upd_ready & i_upd_valid_2;
    pop       = (count_q != '0);
    wr_en_d   = pop;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (push_1) mem_d[wr_ptr_q] = '{addr: i_upd_addr_1, cnt: i_upd_cnt_1, taken: i_upd_taken_1};
    if (push_2) mem_d[wr_ptr_q + PTR_W'(push_1)] =
        '{addr: i_upd_addr_2, cnt: i_upd_cnt_2, taken: i_upd_taken_2};

    wr_ptr_d = wr_ptr_q + PTR_W'(push_1) + PTR_W'(push_2);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + (PTR_W+1)'(push_1) + (PTR_W+1)'(push_2) - (PTR_W+1)'(pop);

    if (pop) begin
      wr_addr_d = head.addr;
      wr_data_d = next_cnt;
    end
  end

  // Control and write-port registers; reset drops any pending entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Entry storage; contents are only meaningful under count, so no reset is needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_pht_update_buffer.sv
// Directed bench for pht_update_buffer with a queue-level reference model.
// Latency: model mirrors edge-level accept/pop timing.
// Backpressure: model honours the registered-count ready rule.
module tb_pht_update_buffer;
  import pht_update_buffer_pkg::*;

  localparam int DEPTH  = GSH_PHT_UPD_BUF_DEPTH;
  localparam int ADDR_W = GSH_PHT_ENT_SEL;
  localparam int CNT_W  = GSH_PHT_DATA_WIDTH;
  localparam int LOG_W  = ADDR_W + CNT_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              v1, v2, t1, t2;
  logic [ADDR_W-1:0] a1, a2;
  logic [CNT_W-1:0]  c1, c2;
  logic              o_upd_ready, o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [CNT_W-1:0]  o_wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pht_update_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_upd_valid_1(v1), .i_upd_addr_1(a1), .i_upd_cnt_1(c1), .i_upd_taken_1(t1),
    .i_upd_valid_2(v2), .i_upd_addr_2(a2), .i_upd_cnt_2(c2), .i_upd_taken_2(t2),
    .o_upd_ready(o_upd_ready), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int addr;
    int cnt;
    bit taken;
  } m_upd_t;

  m_upd_t m_q[$];
  bit     m_init = 0;
  bit     m_en;
  int     m_addr, m_data;

  function automatic int sat_step(input int c, input bit taken);
    int mx = (1 << CNT_W) - 1;
    if (taken) return (c >= mx) ? mx : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_en = 0; m_addr = 0; m_data = 0;
      m_init = 1;
    end else if (m_init) begin
      bit rdy;
      rdy = (m_q.size() <= DEPTH - 2);
      if (m_q.size() > 0) begin
        m_upd_t h;
        int base;
        h = m_q.pop_front();
        base = (m_en && m_addr == h.addr) ? m_data : h.cnt;
        m_data = sat_step(base, h.taken);
        m_addr = h.addr;
        m_en = 1;
      end else begin
        m_en = 0;
      end
      if (rdy && v1) m_q.push_back('{addr: int'(a1), cnt: int'(c1), taken: t1});
      if (rdy && v2) m_q.push_back('{addr: int'(a2), cnt: int'(c2), taken: t2});
    end
  end

  // ---------------- compare process + write log ----------------
  logic [LOG_W-1:0] wlog[$];
  logic [LOG_W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (m_init) begin
      chk("ready", int'(o_upd_ready), int'(m_q.size() <= DEPTH - 2));
      chk("wr_en", int'(o_wr_en), int'(m_en));
      chk("wr_addr", int'(o_wr_addr), m_addr);
      chk("wr_data", int'(o_wr_data), m_data);
      if (o_wr_en === 1'b1) wlog.push_back({o_wr_addr, o_wr_data});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit iv1, input int ia1, input int ic1, input bit it1,
                     input bit iv2, input int ia2, input int ic2, input bit it2);
    v1 = iv1; a1 = ADDR_W'(ia1); c1 = CNT_W'(ic1); t1 = it1;
    v2 = iv2; a2 = ADDR_W'(ia2); c2 = CNT_W'(ic2); t2 = it2;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [LOG_W-1:0] ent(input int addr, input int data);
    return {ADDR_W'(addr), CNT_W'(data)};
  endfunction

  task automatic check_log(input string name);
    #1;
    chk({name, "_count"}, wlog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
      chk($sformatf("%s_w%0d", name, i), int'(wlog[i]), int'(exp_q[i]));
    wlog.delete();
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    v1 = 0; a1 = '0; c1 = '0; t1 = 0;
    v2 = 0; a2 = '0; c2 = '0; t2 = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wr_en", int'(o_wr_en), 0);
    chk("rst_wr_addr", int'(o_wr_addr), 0);
    chk("rst_wr_data", int'(o_wr_data), 0);
    chk("rst_ready", int'(o_upd_ready), 1);
    rst_n = 1'b1;
    idle(1);

    // Single update: accepted at edge N, written during the cycle after edge N+1.
    cyc(1, 'h15, 1, 1, 0, 0, 0, 0);
    chk("single_lat_n", int'(o_wr_en), 0);
    idle(1);
    chk("single_en", int'(o_wr_en), 1);
    chk("single_addr", int'(o_wr_addr), 'h15);
    chk("single_data", int'(o_wr_data), 2);
    idle(1);
    chk("single_after", int'(o_wr_en), 0);
    idle(3);
    exp_q.push_back(ent('h15, 2));
    check_log("single");

    // Saturation at both ends.
    cyc(1, 'h20, 3, 1, 1, 'h21, 0, 0);
    idle(5);
    exp_q.push_back(ent('h20, 3));
    exp_q.push_back(ent('h21, 0));
    check_log("sat");

    // Forwarding between consecutive same-index updates.
    cyc(1, 'h07, 1, 1, 1, 'h07, 1, 1);
    idle(5);
    exp_q.push_back(ent('h07, 2));
    exp_q.push_back(ent('h07, 3));
    check_log("fwd");

    // Fill: third pair arrives while ready is low and must be dropped.
    cyc(1, 'h30, 1, 1, 1, 'h31, 1, 1);
    chk("fill_rdy_a", int'(o_upd_ready), 1);
    cyc(1, 'h32, 1, 1, 1, 'h33, 1, 1);
    chk("fill_rdy_b", int'(o_upd_ready), 0);
    cyc(1, 'h34, 1, 1, 1, 'h35, 1, 1);
    chk("fill_rdy_c", int'(o_upd_ready), 1);
    idle(6);
    exp_q.push_back(ent('h30, 2));
    exp_q.push_back(ent('h31, 2));
    exp_q.push_back(ent('h32, 2));
    exp_q.push_back(ent('h33, 2));
    check_log("fill");

    // Lone slot 2.
    cyc(0, 0, 0, 0, 1, 'h3A, 2, 0);
    idle(4);
    exp_q.push_back(ent('h3A, 1));
    check_log("lone2");

    // Reset while three entries are pending.
    cyc(1, 'h40, 1, 1, 1, 'h41, 1, 1);
    cyc(1, 'h42, 1, 1, 1, 'h43, 1, 1);
    chk("mid_en", int'(o_wr_en), 1);
    rst_n = 1'b0;
    idle(1);
    chk("mid_rst_en", int'(o_wr_en), 0);
    chk("mid_rst_ready", int'(o_upd_ready), 1);
    rst_n = 1'b1;
    idle(5);
    chk("mid_post_en", int'(o_wr_en), 0);
    exp_q.push_back(ent('h40, 2));
    check_log("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
